// File: rtl/key_debounce_3ch_pkg.sv
// rtl/key_debounce_3ch_pkg.sv - shared constants and FSM encoding for the key debouncer
// Optional feature macro used by the design files: KEY_RELEASE_PULSE_EN
package key_debounce_3ch_pkg;

  localparam int   KEY_NUM    = 3;
  localparam logic KEY_ACTIVE = 1'b0;
  localparam logic KEY_IDLE   = 1'b1;

  // Stable debounced level of one key; encoding equals the active-low key level.
  typedef enum logic {
    STABLE_LO = 1'b0,
    STABLE_HI = 1'b1
  } key_state_e;

  // Terminal count of the debounce window for a clock frequency and hold time.
  function automatic int calc_cnt_max(input int clk_freq, input int debounce_ms);
    return clk_freq / 1000 * debounce_ms - 1;
  endfunction

  // Counter width that holds cnt_max exactly, never below one bit.
  function automatic int calc_cnt_w(input int cnt_max);
    return (cnt_max > 0) ? $clog2(cnt_max + 1) : 1;
  endfunction

endpackage

// File: rtl/key_debounce_3ch_ch.sv
// rtl/key_debounce_3ch_ch.sv - one key channel: 2-flop sync, debounce counter, FSM, strobes
// key_release exists only when KEY_RELEASE_PULSE_EN is defined.
module key_debounce_ch
  import key_debounce_3ch_pkg::*;
#(
  parameter int CNT_MAX = 9
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_out,
`ifdef KEY_RELEASE_PULSE_EN
  output logic key_release,
`endif
  output logic key_press
);

  localparam int              CNT_W    = calc_cnt_w(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);

  logic             s1_q;
  logic             s2_q;
  key_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             key_out_q;
  logic             press_q;
`ifdef KEY_RELEASE_PULSE_EN
  logic             release_q;
`endif

  // Two-flop synchroniser; resets to the released level so reset exit looks idle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_q <= KEY_IDLE;
      s2_q <= KEY_IDLE;
    end else begin
      s1_q <= key_in;
      s2_q <= s1_q;
    end
  end

  // Stable-level FSM: the synchronised input must differ for CNT_MAX+1 cycles in a row to flip.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= STABLE_HI;
      cnt_q     <= '0;
      key_out_q <= KEY_IDLE;
      press_q   <= 1'b0;
`ifdef KEY_RELEASE_PULSE_EN
      release_q <= 1'b0;
`endif
    end else begin
      press_q   <= 1'b0;
`ifdef KEY_RELEASE_PULSE_EN
      release_q <= 1'b0;
`endif
      if (s2_q == logic'(state_q)) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_LAST) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
        case (state_q)
          STABLE_HI: begin
            state_q   <= STABLE_LO;
            key_out_q <= KEY_ACTIVE;
            press_q   <= 1'b1;
          end
          default: begin
            state_q   <= STABLE_HI;
            key_out_q <= KEY_IDLE;
`ifdef KEY_RELEASE_PULSE_EN
            release_q <= 1'b1;
`endif
          end
        endcase
      end
    end
  end

  assign key_out   = key_out_q;
  assign key_press = press_q;
`ifdef KEY_RELEASE_PULSE_EN
  assign key_release = release_q;
`endif

endmodule

// File: rtl/key_debounce_3ch.sv
// rtl/key_debounce_3ch.sv - three independent debounced active-low keys with press strobes
// Defining KEY_RELEASE_PULSE_EN adds the key_release strobe port.
module key_debounce_3ch
  import key_debounce_3ch_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_out,
`ifdef KEY_RELEASE_PULSE_EN
  output logic [KEY_NUM-1:0] key_release,
`endif
  output logic [KEY_NUM-1:0] key_press
);

  localparam int CNT_MAX = calc_cnt_max(CLK_FREQ, DEBOUNCE_MS);

  // One fully independent channel per key; bit 0 is key1.
  for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
    key_debounce_ch #(
      .CNT_MAX (CNT_MAX)
    ) u_ch (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .key_in      (key_in[i]),
      .key_out     (key_out[i]),
`ifdef KEY_RELEASE_PULSE_EN
      .key_release (key_release[i]),
`endif
      .key_press   (key_press[i])
    );
  end

endmodule

// File: tb/tb_key_debounce_3ch.sv
// tb/tb_key_debounce_3ch.sv - scoreboard bench for key_debounce_3ch against a window-based model
module tb_key_debounce_3ch;

  localparam int CNT_MAX = 9;

  typedef struct packed {
    logic [2:0] out;
    logic [2:0] press;
    logic [2:0] rel;
  } exp_t;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [2:0] key_in;
  logic [2:0] key_out;
  logic [2:0] key_press;
`ifdef KEY_RELEASE_PULSE_EN
  logic [2:0] key_release;
`endif

  key_debounce_3ch #(
    .CLK_FREQ    (1000),
    .DEBOUNCE_MS (10)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .key_in      (key_in),
    .key_out     (key_out),
`ifdef KEY_RELEASE_PULSE_EN
    .key_release (key_release),
`endif
    .key_press   (key_press)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  int   n_vec  = 0;
  int   n_miss = 0;
  exp_t sb[$];

  // Model state: every synchroniser sample since time zero, the debounced level,
  // and the edge index of the last flip (or reset) for each channel.
  logic [2:0] hist[$];
  logic [2:0] level;
  int         last_flip[3];

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  // Output level flips at edge n when every synchronised sample seen at edges
  // n-CNT_MAX..n differs from the current level and none of those edges precede
  // the last flip/reset. Edge j sees the key sampled at edge j-2.
  task automatic model_step(input logic [2:0] k, input logic r);
    exp_t       e;
    int         n;
    logic [2:0] smp;
    bit         ok;
    e.press = '0;
    e.rel   = '0;
    if (!r) begin
      hist.push_back(3'b111);
      n = hist.size() - 1;
      level = 3'b111;
      for (int c = 0; c < 3; c++) last_flip[c] = n;
    end else begin
      hist.push_back(k);
      n = hist.size() - 1;
      for (int c = 0; c < 3; c++) begin
        ok = 1'b1;
        for (int j = n - CNT_MAX; j <= n; j++) begin
          if (j <= last_flip[c] || j < 2) begin
            ok = 1'b0;
          end else begin
            smp = hist[j-2];
            if (smp[c] == level[c]) ok = 1'b0;
          end
        end
        if (ok) begin
          level[c]     = ~level[c];
          last_flip[c] = n;
          if (level[c] == 1'b0) e.press[c] = 1'b1;
          else                  e.rel[c]   = 1'b1;
        end
      end
    end
    e.out = level;
    sb.push_back(e);
  endtask

  // Drive one cycle at the falling edge, then run the model at the rising edge.
  task automatic cycle(input logic [2:0] k, input logic r);
    @(negedge sys_clk);
    key_in    = k;
    sys_rst_n = r;
    if (!r) begin
      #1;
      check("reset_out_async", key_out, 3'b111);
      check("reset_press_async", key_press, 3'b000);
    end
    @(posedge sys_clk);
    model_step(k, r);
  endtask

  task automatic run(input logic [2:0] k, input int n);
    for (int i = 0; i < n; i++) cycle(k, 1'b1);
  endtask

  // Monitor: registered outputs are sampled 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge sys_clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("key_out", key_out, e.out);
        check("key_press", key_press, e.press);
`ifdef KEY_RELEASE_PULSE_EN
        check("key_release", key_release, e.rel);
`endif
      end
    end
  end

  initial begin
    logic [2:0] k;
    int         hold[3];
    for (int c = 0; c < 3; c++) last_flip[c] = -1;
    level     = 3'b111;
    key_in    = 3'b000;
    sys_rst_n = 1'b0;

    // Reset held with all keys pressed.
    for (int i = 0; i < 5; i++) cycle(3'b000, 1'b0);
    run(3'b111, 4);

    // Clean press on key1, held.
    run(3'b110, 20);
    // Short 8-cycle glitch on key2 must not pass.
    run(3'b100, 8);
    run(3'b110, 15);
    // Key3 bounces every 3 cycles for 30 cycles, then holds low.
    k = 3'b110;
    for (int i = 0; i < 10; i++) begin
      k[2] = ~k[2];
      run(k, 3);
    end
    run(3'b010, 20);
    // Press key2 so all are low, then release all together.
    run(3'b000, 15);
    run(3'b111, 15);

    // Reset mid-count with key1 held, then re-qualification.
    run(3'b110, 7);
    for (int i = 0; i < 3; i++) cycle(3'b110, 1'b0);
    run(3'b110, 16);
    run(3'b111, 15);

    // Boundary glitches of exactly CNT_MAX and CNT_MAX+1 synchronised cycles.
    run(3'b000, CNT_MAX);
    run(3'b111, 15);
    run(3'b000, CNT_MAX + 1);
    run(3'b111, 15);

    // Random independent bouncing with occasional resets.
    k = 3'b111;
    for (int c = 0; c < 3; c++) hold[c] = $urandom_range(14, 1);
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < 3; c++) begin
        hold[c]--;
        if (hold[c] == 0) begin
          k[c]    = ~k[c];
          hold[c] = $urandom_range(14, 1);
        end
      end
      cycle(k, ($urandom_range(299, 0) == 0) ? 1'b0 : 1'b1);
    end

    run(3'b111, 3);
    @(posedge sys_clk);
    #2;
    check("scoreboard_drained", 3'(sb.size()), 3'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
